// File: rtl/muldiv_hilo_unit_if.sv
// rtl/muldiv_hilo_unit_if.sv - E-stage issue/stall handshake and HI/LO result bundle for the mul/div unit
interface muldiv_hilo_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             flush;
    logic             stall_e;
    logic             stall_o;
    logic [WIDTH-1:0] hi_o;
    logic [WIDTH-1:0] lo_o;
    logic             done;
    logic             div_by_zero;

    modport master (
        output start, op, a, b, flush, stall_e,
        input  stall_o, hi_o, lo_o, done, div_by_zero
    );

    modport slave (
        input  start, op, a, b, flush, stall_e,
        output stall_o, hi_o, lo_o, done, div_by_zero
    );
endinterface

// File: rtl/muldiv_hilo_unit.sv
// rtl/muldiv_hilo_unit.sv - multi-cycle MULT/MULTU/DIV/DIVU unit with integrated HI/LO and E-stage stall request
module muldiv_hilo_unit #(
    parameter int WIDTH       = 32,
    parameter int MUL_LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst,
    muldiv_hilo_unit_if.slave bus
);
    localparam int CNT_MAX = (WIDTH > MUL_LATENCY) ? WIDTH : MUL_LATENCY;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;
    state_t r_state, w_next;

    logic [CNT_W-1:0]   r_cnt;
    // Multiply: raw operands. Divide: r_a is the dividend shifting out / quotient shifting in, r_b the divisor magnitude.
    logic [WIDTH-1:0]   r_a, r_b, r_rem, r_hi, r_lo;
    logic               r_signed, r_neg_q, r_neg_r, r_done, r_dbz;

    logic               w_issue, w_is_mul, w_is_div, w_b_zero, w_last, w_stall;
    logic               w_a_neg, w_b_neg, w_qbit;
    logic [WIDTH-1:0]   w_a_mag, w_b_mag, w_rem_nx, w_quo_nx;
    logic [2*WIDTH-1:0] w_ma, w_mb, w_prod;
    logic [WIDTH:0]     w_rem_sh, w_diff;

    assign w_issue  = bus.start & ~bus.flush & (r_state == S_IDLE);
    assign w_is_mul = (bus.op == OP_MULT) | (bus.op == OP_MULTU);
    assign w_is_div = (bus.op == OP_DIV) | (bus.op == OP_DIVU);
    assign w_b_zero = (bus.b == '0);
    assign w_last   = (r_cnt == '0);

    assign w_a_neg  = (bus.op == OP_DIV) & bus.a[WIDTH-1];
    assign w_b_neg  = (bus.op == OP_DIV) & bus.b[WIDTH-1];
    assign w_a_mag  = w_a_neg ? -bus.a : bus.a;
    assign w_b_mag  = w_b_neg ? -bus.b : bus.b;

    // Sign-extending to 2*WIDTH lets one unsigned multiplier serve both MULT and MULTU.
    assign w_ma     = {{WIDTH{r_signed & r_a[WIDTH-1]}}, r_a};
    assign w_mb     = {{WIDTH{r_signed & r_b[WIDTH-1]}}, r_b};
    assign w_prod   = w_ma * w_mb;

    assign w_rem_sh = {r_rem, r_a[WIDTH-1]};
    assign w_diff   = w_rem_sh - {1'b0, r_b};
    assign w_qbit   = w_rem_sh[WIDTH] | ~w_diff[WIDTH];
    assign w_rem_nx = w_qbit ? w_diff[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
    assign w_quo_nx = {r_a[WIDTH-2:0], w_qbit};

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next  = r_state;
        w_stall = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_issue && w_is_mul) begin
                    w_next  = S_MUL;
                    w_stall = 1'b1;
                end else if (w_issue && w_is_div) begin
                    w_next  = w_b_zero ? S_DONE : S_DIV;
                    w_stall = 1'b1;
                end
            end
            S_MUL, S_DIV: begin
                w_stall = 1'b1;
                if (w_last) w_next = S_DONE;
            end
            S_DONE:  if (!bus.stall_e) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        if (bus.flush) w_next = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_rem    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_signed <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_done   <= 1'b0;
            r_dbz    <= 1'b0;
        end else begin
            r_done <= (w_next == S_DONE) && (r_state != S_DONE);
            r_dbz  <= w_issue & w_is_div & w_b_zero;
            if (!bus.flush) begin
                case (r_state)
                    S_IDLE: if (w_issue) begin
                        if (bus.op == OP_MTHI) r_hi <= bus.a;
                        if (bus.op == OP_MTLO) r_lo <= bus.a;
                        if (w_is_mul) begin
                            r_a      <= bus.a;
                            r_b      <= bus.b;
                            r_signed <= (bus.op == OP_MULT);
                            r_cnt    <= CNT_W'(MUL_LATENCY - 1);
                        end
                        if (w_is_div) begin
                            r_a     <= w_a_mag;
                            r_b     <= w_b_mag;
                            r_rem   <= '0;
                            r_neg_q <= w_a_neg ^ w_b_neg;
                            r_neg_r <= w_a_neg;
                            r_cnt   <= CNT_W'(WIDTH - 1);
                        end
                    end
                    S_MUL: begin
                        r_cnt <= r_cnt - 1'b1;
                        if (w_last) {r_hi, r_lo} <= w_prod;
                    end
                    S_DIV: begin
                        r_cnt <= r_cnt - 1'b1;
                        r_a   <= w_quo_nx;
                        r_rem <= w_rem_nx;
                        if (w_last) begin
                            r_lo <= r_neg_q ? -w_quo_nx : w_quo_nx;
                            r_hi <= r_neg_r ? -w_rem_nx : w_rem_nx;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.stall_o     = w_stall;
    assign bus.hi_o        = r_hi;
    assign bus.lo_o        = r_lo;
    assign bus.done        = r_done;
    assign bus.div_by_zero = r_dbz;
endmodule

// File: tb/tb_muldiv_hilo_unit.sv
// tb/tb_muldiv_hilo_unit.sv - directed and randomized checks of muldiv_hilo_unit against an arithmetic model
module tb_muldiv_hilo_unit;
    localparam int W   = 32;
    localparam int LAT = 2;
    localparam logic [2:0] NOP = 3'd0, MULT = 3'd1, MULTU = 3'd2, DIV = 3'd3;
    localparam logic [2:0] DIVU = 3'd4, MTHI = 3'd5, MTLO = 3'd6, OP7 = 3'd7;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    muldiv_hilo_unit_if #(.WIDTH(32)) bus ();
    muldiv_hilo_unit_if #(.WIDTH(16)) bus16 ();

    muldiv_hilo_unit #(.WIDTH(32), .MUL_LATENCY(LAT)) dut (.clk(clk), .rst(rst), .bus(bus));
    muldiv_hilo_unit #(.WIDTH(16), .MUL_LATENCY(1))   dut16 (.clk(clk), .rst(rst), .bus(bus16));

    int n_pass  = 0;
    int n_total = 0;
    logic [31:0] m_hi = 32'h0;
    logic [31:0] m_lo = 32'h0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Architectural HI/LO update straight from the instruction definitions.
    function automatic bit model_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, p, q, r;
        sa = $signed(a);
        sb = $signed(b);
        model_op = 1'b0;
        case (op)
            MULT:  begin p = sa * sb; m_hi = p[63:32]; m_lo = p[31:0]; end
            MULTU: begin p = {32'h0, a} * {32'h0, b}; m_hi = p[63:32]; m_lo = p[31:0]; end
            DIV:   if (b == 0) model_op = 1'b1;
                   else begin q = sa / sb; r = sa % sb; m_lo = q[31:0]; m_hi = r[31:0]; end
            DIVU:  if (b == 0) model_op = 1'b1;
                   else begin q = {32'h0, a} / {32'h0, b}; r = {32'h0, a} % {32'h0, b}; m_lo = q[31:0]; m_hi = r[31:0]; end
            MTHI:  m_hi = a;
            MTLO:  m_lo = a;
            default: ;
        endcase
    endfunction

    function automatic int exp_cycles(input logic [2:0] op, input logic [31:0] b);
        if (op == MULT || op == MULTU) return LAT + 1;
        return (b == 0) ? 1 : W + 1;
    endfunction

    task automatic drive(input bit sel, input bit st, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (sel) begin
            bus16.start = st; bus16.op = op; bus16.a = a[15:0]; bus16.b = b[15:0];
        end else begin
            bus.start = st; bus.op = op; bus.a = a; bus.b = b;
        end
    endtask

    task automatic check_op(input string tag, input bit sel, input logic [2:0] op, input logic [31:0] a,
                            input logic [31:0] b, input int exp_cyc, input bit exp_dbz,
                            input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int done_cyc, stalls;
        bit dbz, extra;
        logic [31:0] hi, lo;
        done_cyc = -1; stalls = 0; dbz = 1'b0; hi = 'x; lo = 'x;
        @(posedge clk); #1;
        drive(sel, 1'b1, op, a, b);
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (sel ? bus16.stall_o : bus.stall_o) stalls++;
            if (sel ? bus16.done : bus.done) begin
                done_cyc = c;
                dbz = sel ? bus16.div_by_zero : bus.div_by_zero;
                hi  = sel ? {16'h0, bus16.hi_o} : bus.hi_o;
                lo  = sel ? {16'h0, bus16.lo_o} : bus.lo_o;
                break;
            end
            @(posedge clk); #1;
            drive(sel, 1'b0, NOP, 32'h0, 32'h0);
        end
        @(posedge clk); #1;
        drive(sel, 1'b0, NOP, 32'h0, 32'h0);
        @(negedge clk);
        extra = sel ? bus16.done : bus.done;
        check({tag, " done_cycle"}, done_cyc, exp_cyc);
        check({tag, " stall_cycles"}, stalls, exp_cyc);
        check({tag, " div_by_zero"}, dbz, exp_dbz);
        check({tag, " hi"}, hi, exp_hi);
        check({tag, " lo"}, lo, exp_lo);
        check({tag, " done_one_pulse"}, extra, 1'b0);
    endtask

    task automatic mt_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        @(posedge clk); #1;
        drive(1'b0, 1'b1, op, a, $urandom);
        @(negedge clk);
        check({tag, " stall_o"}, bus.stall_o, 1'b0);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, NOP, 32'h0, 32'h0);
        @(negedge clk);
        check({tag, " hi"}, bus.hi_o, exp_hi);
        check({tag, " lo"}, bus.lo_o, exp_lo);
        check({tag, " done"}, bus.done, 1'b0);
    endtask

    initial begin
        logic [7:0] done_mask, stall_mask;
        logic [2:0] rop;
        logic [31:0] ra, rb;
        bit rdbz;
        int n_done;

        drive(1'b0, 1'b0, NOP, 32'h0, 32'h0);
        drive(1'b1, 1'b0, NOP, 32'h0, 32'h0);
        bus.flush = 1'b0; bus.stall_e = 1'b0;
        bus16.flush = 1'b0; bus16.stall_e = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset hi", bus.hi_o, 32'h0);
        check("reset lo", bus.lo_o, 32'h0);
        check("reset done", bus.done, 1'b0);
        check("reset dbz", bus.div_by_zero, 1'b0);
        check("reset stall_o", bus.stall_o, 1'b0);
        check("reset16 hi", bus16.hi_o, 16'h0);
        check("reset16 lo", bus16.lo_o, 16'h0);
        check("reset16 stall_o", bus16.stall_o, 1'b0);

        rdbz = model_op(MULT, 32'hFFFFFFFF, 32'h2);
        check_op("mult", 1'b0, MULT, 32'hFFFFFFFF, 32'h2, 3, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFE);
        rdbz = model_op(MULTU, 32'hFFFFFFFF, 32'h2);
        check_op("multu", 1'b0, MULTU, 32'hFFFFFFFF, 32'h2, 3, 1'b0, 32'h00000001, 32'hFFFFFFFE);
        rdbz = model_op(DIV, 32'hFFFFFFF9, 32'h2);
        check_op("div -7/2", 1'b0, DIV, 32'hFFFFFFF9, 32'h2, 33, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFD);
        rdbz = model_op(DIVU, 32'd100, 32'd7);
        check_op("divu 100/7", 1'b0, DIVU, 32'd100, 32'd7, 33, 1'b0, 32'd2, 32'd14);
        rdbz = model_op(DIV, 32'h80000000, 32'hFFFFFFFF);
        check_op("div minneg/-1", 1'b0, DIV, 32'h80000000, 32'hFFFFFFFF, 33, 1'b0, 32'h0, 32'h80000000);
        rdbz = model_op(MTHI, 32'h1234, 32'h0);
        mt_op("mthi", MTHI, 32'h1234, 32'h1234, 32'h80000000);
        rdbz = model_op(DIVU, 32'd7, 32'd0);
        check_op("divu by zero", 1'b0, DIVU, 32'd7, 32'd0, 1, 1'b1, 32'h1234, 32'h80000000);
        mt_op("nop", NOP, 32'hDEADBEEF, m_hi, m_lo);
        mt_op("op7", OP7, 32'hDEADBEEF, m_hi, m_lo);

        // DIV cancelled by flush in cycle 10
        @(posedge clk); #1;
        drive(1'b0, 1'b1, DIV, 32'd1000, 32'd3);
        for (int c = 1; c <= 11; c++) begin
            @(posedge clk); #1;
            drive(1'b0, 1'b0, NOP, 32'h0, 32'h0);
            bus.flush = (c == 10);
        end
        @(negedge clk);
        check("flush stall_o", bus.stall_o, 1'b0);
        check("flush hi", bus.hi_o, m_hi);
        check("flush lo", bus.lo_o, m_lo);
        n_done = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done) n_done++;
        end
        check("flush no done", n_done, 0);

        @(posedge clk); #1;
        drive(1'b0, 1'b1, MTLO, 32'h55, 32'h0);
        bus.flush = 1'b1;
        @(posedge clk); #1;
        drive(1'b0, 1'b0, NOP, 32'h0, 32'h0);
        bus.flush = 1'b0;
        @(negedge clk);
        check("flush mtlo lo", bus.lo_o, m_lo);
        check("flush mtlo done", bus.done, 1'b0);

        // MULT finishing into a stalled E stage with start still held
        @(posedge clk); #1;
        drive(1'b0, 1'b1, MULT, 32'd3, 32'd5);
        for (int c = 0; c < 8; c++) begin
            if (c > 0) begin @(posedge clk); #1; end
            bus.stall_e = (c >= 3 && c <= 5);
            if (c == 7) drive(1'b0, 1'b0, NOP, 32'h0, 32'h0);
            @(negedge clk);
            done_mask[c]  = bus.done;
            stall_mask[c] = bus.stall_o;
        end
        rdbz = model_op(MULT, 32'd3, 32'd5);
        check("stall_e done pulses", done_mask, 8'b0000_1000);
        check("stall_e stall_o", stall_mask, 8'b0000_0111);
        check("stall_e hi", bus.hi_o, 32'h0);
        check("stall_e lo", bus.lo_o, 32'd15);

        for (int i = 0; i < 30; i++) begin
            rop = 3'($urandom_range(1, 6));
            ra  = ($urandom_range(0, 5) == 0) ? 32'h80000000 : $urandom;
            case ($urandom_range(0, 7))
                0:       rb = 32'h0;
                1:       rb = 32'hFFFFFFFF;
                2:       rb = $urandom_range(1, 9);
                default: rb = $urandom;
            endcase
            rdbz = model_op(rop, ra, rb);
            if (rop == MTHI || rop == MTLO) mt_op("rand mt", rop, ra, m_hi, m_lo);
            else check_op("rand", 1'b0, rop, ra, rb, exp_cycles(rop, rb), rdbz, m_hi, m_lo);
        end

        check_op("w16 mult", 1'b1, MULT, 32'h8000, 32'h8000, 2, 1'b0, 32'h4000, 32'h0);
        check_op("w16 div", 1'b1, DIV, 32'h8000, 32'hFFFF, 17, 1'b0, 32'h0, 32'h8000);

        rdbz = model_op(MTHI, 32'hA5A5, 32'h0);
        mt_op("mthi pre-reset", MTHI, 32'hA5A5, m_hi, m_lo);
        rdbz = model_op(MTLO, 32'h5A5A, 32'h0);
        mt_op("mtlo pre-reset", MTLO, 32'h5A5A, 32'hA5A5, 32'h5A5A);
        @(posedge clk); #1;
        drive(1'b0, 1'b1, MULT, 32'h12345, 32'h777);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, NOP, 32'h0, 32'h0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("midop reset hi", bus.hi_o, 32'h0);
        check("midop reset lo", bus.lo_o, 32'h0);
        check("midop reset stall_o", bus.stall_o, 1'b0);
        n_done = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.done) n_done++;
        end
        check("midop reset no done", n_done, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/muldiv_hilo_unit.md
# muldiv_hilo_unit

Parametrised multiply/divide unit with integrated HI/LO register, replacing the fixed 32-bit divider-in-ALU plus separate HI/LO register in the 5-stage MIPS datapath. It sits beside the execute-stage ALU, accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the E stage, and drives a stall request into the hazard unit while a multi-cycle operation runs. It supports configurable data width and multiplier latency, flush cancellation, and divide-by-zero reporting.

## Interface
- WIDTH, 32: operand and HI/LO width (even, ≥ 8)
- MUL_LATENCY, 2: cycles spent in MUL state (≥ 1)

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  E stage holds a valid mul/div/move op
- op  in  3  000 NOP, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO; 111 treated as NOP
- a  in  WIDTH  rs operand (dividend / multiplicand / move source)
- b  in  WIDTH  rt operand (divisor / multiplier)
- flush  in  1  cancel in-flight and issuing op
- stall_e  in  1  E stage stalled by another cause
- stall_o  out  1  request E-and-earlier stall
- hi_o  out  WIDTH  committed HI
- lo_o  out  WIDTH  committed LO
- done  out  1  one-cycle pulse, first cycle new HI/LO visible
- div_by_zero  out  1  pulses with done when DIV/DIVU had b==0

## Operation
- States: IDLE, MUL, DIV, DONE. Issue = start & ~flush & state==IDLE.
- IDLE: issue of MULT/MULTU → MUL; DIV/DIVU → DIV; MTHI/MTLO write hi_o/lo_o ← a at this edge, stay IDLE, no done; NOP/111 ignored.
- MUL: counter runs MUL_LATENCY cycles; on last cycle write {hi_o,lo_o} ← 2·WIDTH product (signed for MULT, unsigned for MULTU), → DONE.
- DIV: operands latched at issue; signed ops converted to magnitudes. Restoring radix-2, one quotient bit per cycle, WIDTH cycles. On last cycle apply signs and write lo_o ← quotient, hi_o ← remainder, → DONE.
- Sign rules (DIV): quotient negative iff a[MSB]^b[MSB]; remainder takes sign of a. Most-negative ÷ −1: lo_o = most-negative (wraps), hi_o = 0.
- Divide by zero: on issue with b==0 go directly to DONE with no HI/LO write; div_by_zero high with done.
- DONE: start ignored (blocks re-issue of the still-resident E instruction). done and div_by_zero high only in the first DONE cycle. → IDLE when stall_e==0; otherwise hold DONE.
- flush (any state): → IDLE at edge, no HI/LO write, no done; also cancels an MTHI/MTLO issuing that cycle.
- Priority: rst > flush > state logic.
- stall_o (combinational) = (state==MUL) | (state==DIV) | (issue of MULT/MULTU/DIV/DIVU with b≠0 or MULT*). Low in DONE and IDLE otherwise. Div-by-zero issue also asserts stall_o for its issue cycle.

## Timing
- Reset: state IDLE; hi_o=0, lo_o=0, done=0, div_by_zero=0; stall_o=0 when start=0.
- Issue at cycle 0 (edge at end of cycle 0).
- MULT/MULTU: stall_o high cycles 0..MUL_LATENCY; HI/LO written at end of cycle MUL_LATENCY; done high cycle MUL_LATENCY+1.
- DIV/DIVU (b≠0): stall_o high cycles 0..WIDTH; done cycle WIDTH+1.
- Div by zero: stall_o high cycle 0; done+div_by_zero cycle 1.
- MTHI/MTLO: new value on hi_o/lo_o in cycle 1; no stall.
- Back-to-back: next issue no earlier than cycle after leaving DONE.
- Reset mid-operation: next cycle IDLE, HI/LO = 0, no done.

## Test plan
- Reset, then MULT a=0xFFFFFFFF b=0x00000002 (WIDTH 32, latency 2) -> stall_o cycles 0–2, done cycle 3, hi_o=0xFFFFFFFF lo_o=0xFFFFFFFE; MULTU same operands -> hi_o=0x00000001 lo_o=0xFFFFFFFE.
- DIV a=0xFFFFFFF9 (−7) b=2 -> stall_o 33 cycles, done cycle 33, lo_o=0xFFFFFFFD hi_o=0xFFFFFFFF; DIVU 100/7 -> lo_o=14 hi_o=2.
- DIV a=0x80000000 b=0xFFFFFFFF -> lo_o=0x80000000 hi_o=0; DIVU 7/0 after MTHI 0x1234 -> done+div_by_zero cycle 1, hi_o stays 0x1234.
- Issue DIV, assert flush in cycle 10 -> IDLE cycle 11, stall_o low, no done, HI/LO unchanged; flush together with MTLO 0x55 -> lo_o unchanged.
- MULT completes with stall_e=1 for 3 cycles while start held -> done single pulse, DONE held 3 cycles, no re-issue, stall_o low throughout hold.
- WIDTH=16, MUL_LATENCY=1: MULT 0x8000×0x8000 -> hi_o=0x4000 lo_o=0x0000 done cycle 2; DIV 0x8000/0xFFFF -> lo_o=0x8000 hi_o=0 done cycle 17.
